inst_fetch_unit: RTL and testbench

- Producer end of the opcode path. Fetches 32-bit instruction words from instruction memory and holds them in an instruction register.
- Presents the opcode field, instruction and PC to the decode/control stage over a valid/ready handshake.
- Accepts single-cycle redirects (branch/jump/JAL targets) from the execute side and squashes any stale fetch.

---
 rtl/inst_fetch_unit.sv | 125 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: fetches 32-bit words from imem into an instruction register and
// hands them to decode over valid/ready. Define IFU_ALIGN_CHECK_EN to add fetch_fault.
module inst_fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [5:0]        op,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] pc_plus4,
`ifdef IFU_ALIGN_CHECK_EN
   output logic              fetch_fault,
`endif
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      StBoot  = 2'd0,
      StFetch = 2'd1,
      StHold  = 2'd2,
      StFault = 2'd3
   } ifuState_e;

   ifuState_e         stateQ, stateD;
   logic [ADDR_W-1:0] pcQ, pcD;
   logic [31:0]       instQ, instD;
   logic [ADDR_W-1:0] instPcQ, instPcD;
   logic              validQ, validD;
`ifdef IFU_ALIGN_CHECK_EN
   logic              faultQ, faultD;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ  <= StBoot;
         pcQ     <= RESET_PC;
         instQ   <= '0;
         instPcQ <= '0;
         validQ  <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
         faultQ  <= 1'b0;
`endif
      end else begin
         stateQ  <= stateD;
         pcQ     <= pcD;
         instQ   <= instD;
         instPcQ <= instPcD;
         validQ  <= validD;
`ifdef IFU_ALIGN_CHECK_EN
         faultQ  <= faultD;
`endif
      end
   end

   always_comb begin
      stateD  = stateQ;
      pcD     = pcQ;
      instD   = instQ;
      instPcD = instPcQ;
      validD  = validQ;
`ifdef IFU_ALIGN_CHECK_EN
      faultD  = faultQ;
`endif

      unique case (stateQ)
         StBoot: begin
            stateD = StFetch;
         end
         StFetch: begin
            if (imem_ack) begin
               instD   = imem_rdata;
               instPcD = pcQ;
               pcD     = pcQ + ADDR_W'(4);
               validD  = 1'b1;
               stateD  = StHold;
            end
         end
         StHold: begin
            if (validQ && inst_ready) begin
               validD = 1'b0;
               stateD = StFetch;
            end
         end
         StFault: begin
            validD = 1'b0;
         end
      endcase

      // A redirect wins over any capture or handshake in the same cycle; the stale word is dropped.
      if (redirect_valid && (stateQ != StFault)) begin
         instD   = instQ;
         instPcD = instPcQ;
         validD  = 1'b0;
         pcD     = redirect_pc;
         stateD  = StFetch;
`ifdef IFU_ALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) begin
            stateD = StFault;
            faultD = 1'b1;
         end
`endif
      end
   end

   assign imem_req   = (stateQ == StFetch);
   assign imem_addr  = pcQ;
   assign inst_valid = validQ;
   assign inst       = instQ;
   assign op         = instQ[31:26];
   assign inst_pc    = instPcQ;
   assign pc_plus4   = instPcQ + ADDR_W'(4);
`ifdef IFU_ALIGN_CHECK_EN
   assign fetch_fault = faultQ;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios then randomized traffic,
// all checked against a transaction-level fetch model. Honours IFU_ALIGN_CHECK_EN.
module tb_inst_fetch_unit;

`ifdef IFU_ALIGN_CHECK_EN
   localparam bit AlignChk = 1'b1;
`else
   localparam bit AlignChk = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [5:0]  op;
   logic [31:0] inst_pc;
   logic [31:0] pc_plus4;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef IFU_ALIGN_CHECK_EN
   logic        fetchFault;
`endif

   int numChecks = 0;
   int numErrors = 0;

   // Reference model state
   bit          mBoot, mReq, mValid, mFault;
   logic [31:0] mPc, mInst, mInstPc;

   inst_fetch_unit #(
      .ADDR_W  (32),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
      .op            (op),
      .inst_pc       (inst_pc),
      .pc_plus4      (pc_plus4),
`ifdef IFU_ALIGN_CHECK_EN
      .fetch_fault   (fetchFault),
`endif
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      if (addr == 32'h0) return 32'h8C08_0004;
      return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      numChecks++;
      if (obs !== exp) begin
         numErrors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkModel();
      checkVal("imem_req", 32'(imem_req), 32'(mReq));
      checkVal("imem_addr", imem_addr, mPc);
      checkVal("inst_valid", 32'(inst_valid), 32'(mValid));
      checkVal("inst", inst, mInst);
      checkVal("op", 32'(op), 32'(mInst[31:26]));
      checkVal("inst_pc", inst_pc, mInstPc);
      checkVal("pc_plus4", pc_plus4, mInstPc + 32'd4);
`ifdef IFU_ALIGN_CHECK_EN
      checkVal("fetch_fault", 32'(fetchFault), 32'(mFault));
`endif
   endtask

   // One clock of the fetch contract expressed as transactions.
   task automatic modelStep(input bit ack, input bit rdy, input bit rdv, input logic [31:0] rpc);
      if (mFault) begin
         mReq   = 1'b0;
         mValid = 1'b0;
      end else if (rdv) begin
         mValid = 1'b0;
         mBoot  = 1'b0;
         mPc    = rpc;
         if (AlignChk && rpc[1:0] != 2'b00) begin
            mFault = 1'b1;
            mReq   = 1'b0;
         end else begin
            mReq = 1'b1;
         end
      end else if (mBoot) begin
         mBoot = 1'b0;
         mReq  = 1'b1;
      end else if (mReq && ack) begin
         mInst   = memWord(mPc);
         mInstPc = mPc;
         mPc     = mPc + 32'd4;
         mValid  = 1'b1;
         mReq    = 1'b0;
      end else if (mValid && rdy) begin
         mValid = 1'b0;
         mReq   = 1'b1;
      end
   endtask

   // Called at posedge+1; checks mid-cycle, returns at the next posedge+1.
   task automatic cyc(input bit ackEn, input bit rdy, input bit rdv, input logic [31:0] rpc);
      bit ack;
      ack            = ackEn && mReq;
      imem_ack       = ack;
      imem_rdata     = memWord(imem_addr);
      inst_ready     = rdy;
      redirect_valid = rdv;
      redirect_pc    = rpc;
      #3;
      checkModel();
      modelStep(ack, rdy, rdv, rpc);
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst_n          = 1'b0;
      imem_ack       = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      #1;
      mBoot   = 1'b1;
      mReq    = 1'b0;
      mValid  = 1'b0;
      mFault  = 1'b0;
      mPc     = 32'h0;
      mInst   = 32'h0;
      mInstPc = 32'h0;
      checkModel();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] rpc;
      bit          rdv;
      #1;
      applyReset();

      // Boot and zero-latency fetch of word 0
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      checkVal("boot_op", 32'(op), 32'(6'b100011));
      checkVal("boot_valid", 32'(inst_valid), 32'd1);
      // Backpressure for 5 cycles, then accept
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      checkVal("next_addr", imem_addr, 32'h4);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      // 3-cycle latency at address 8
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      // Redirect with simultaneous ack: data discarded
      cyc(1, 0, 1, 32'h40);
      checkVal("redir_fetch_addr", imem_addr, 32'h40);
      checkVal("redir_fetch_valid", 32'(inst_valid), 32'd0);
      cyc(1, 0, 0, 0);
      // Redirect in HOLD with handshake
      cyc(0, 1, 1, 32'h100);
      checkVal("redir_hold_addr", imem_addr, 32'h100);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      // Wrap at the top of the address space
      cyc(0, 0, 1, 32'hFFFF_FFFC);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      checkVal("wrap_addr", imem_addr, 32'h0);
      // Reset while a fetch is outstanding
      cyc(0, 0, 0, 0);
      applyReset();
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         rdv = ($urandom_range(0, 99) < 8);
         rpc = $urandom;
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
         if (AlignChk || $urandom_range(0, 9) != 0) rpc = rpc & ~32'h3;
         cyc($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 60, rdv, rpc);
      end

`ifdef IFU_ALIGN_CHECK_EN
      // Misaligned redirect traps until reset
      cyc(0, 0, 1, 32'h102);
      checkVal("fault_set", 32'(fetchFault), 32'd1);
      checkVal("fault_req", 32'(imem_req), 32'd0);
      for (int i = 0; i < 4; i++) cyc(1, 1, 1, 32'h200);
      applyReset();
      checkVal("fault_clear", 32'(fetchFault), 32'd0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule
